// File: rtl/cond_sequencer.sv
// cond_sequencer: NZCV flag register, condition evaluation and architectural write gating.
// Optional COND_NV_TRAP_EN makes the 1111 condition set a sticky Undef flag.
module cond_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic             CondLatch,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             NextPC,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             CntClr,
    output logic [3:0]       Flags,
    output logic             CondEx,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [CNT_W-1:0] SquashCnt,
    output logic             Undef
);
    logic n, z, c, v, ge, base, pass;
    assign {n, z, c, v} = Flags;
    assign ge = (n == v);
    // Odd encodings are the complement of the even one below them; 1111 is forced to never.
    always_comb begin
        case (Cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = ge;
            3'd6:    base = ~z & ge;
            default: base = 1'b1;
        endcase
        pass = (Cond == 4'hF) ? 1'b0 : base ^ Cond[0];
    end
    assign PCWrite  = (PCS & CondEx) | NextPC;
    assign RegWrite = RegW & CondEx;
    assign MemWrite = MemW & CondEx;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Flags     <= 4'b0000;
            CondEx    <= 1'b0;
            SquashCnt <= '0;
        end else begin
            if (FlagW[1] & CondEx) Flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0] & CondEx) Flags[1:0] <= ALUFlags[1:0];
            if (CondLatch) CondEx <= pass;
            if (CntClr) SquashCnt <= '0;
            else if (CondLatch & ~pass & ~&SquashCnt) SquashCnt <= SquashCnt + CNT_W'(1);
        end
    end
`ifdef COND_NV_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) Undef <= 1'b0;
        else if (CntClr) Undef <= 1'b0;
        else if (CondLatch & (Cond == 4'hF)) Undef <= 1'b1;
    end
`else
    assign Undef = 1'b0;
`endif
endmodule

// File: tb/tb_cond_sequencer.sv
// tb_cond_sequencer: directed and random checks of cond_sequencer against a behavioural model.
module tb_cond_sequencer;
    logic clk = 0, reset = 1;
    logic [3:0] Cond = 0, ALUFlags = 0;
    logic CondLatch = 0, PCS = 0, NextPC = 0, RegW = 0, MemW = 0, CntClr = 0;
    logic [1:0] FlagW = 0;
    logic [3:0] Flags;
    logic CondEx, PCWrite, RegWrite, MemWrite, Undef;
    logic [3:0] SquashCnt;
    int total = 0, bad = 0;
    logic [3:0] mf;
    logic mce, mund;
    int mcnt;

    cond_sequencer #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .CondLatch(CondLatch),
        .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .CntClr(CntClr),
        .Flags(Flags), .CondEx(CondEx), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .SquashCnt(SquashCnt), .Undef(Undef)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ev(input logic [3:0] cd, input logic [3:0] f);
        logic fn, fz, fc, fv;
        {fn, fz, fc, fv} = f;
        case (cd)
            4'h0: return fz;
            4'h1: return !fz;
            4'h2: return fc;
            4'h3: return !fc;
            4'h4: return fn;
            4'h5: return !fn;
            4'h6: return fv;
            4'h7: return !fv;
            4'h8: return fc && !fz;
            4'h9: return !fc || fz;
            4'hA: return fn == fv;
            4'hB: return fn != fv;
            4'hC: return !fz && (fn == fv);
            4'hD: return fz || (fn != fv);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        mf = 0; mce = 0; mcnt = 0; mund = 0;
    endtask

    task automatic check_comb();
        chk("pcwrite", 16'(PCWrite), 16'((PCS & mce) | NextPC));
        chk("regwrite", 16'(RegWrite), 16'(RegW & mce));
        chk("memwrite", 16'(MemWrite), 16'(MemW & mce));
    endtask

    task automatic check_all();
        chk("flags", 16'(Flags), 16'(mf));
        chk("condex", 16'(CondEx), 16'(mce));
        chk("squashcnt", 16'(SquashCnt), 16'(mcnt));
        chk("undef", 16'(Undef), 16'(mund));
        check_comb();
    endtask

    task automatic set(input logic [3:0] cd, input logic [3:0] alu, input logic cl,
                       input logic [1:0] fw, input logic pcs, input logic npc,
                       input logic rw, input logic mw, input logic clr);
        Cond = cd; ALUFlags = alu; CondLatch = cl; FlagW = fw; PCS = pcs;
        NextPC = npc; RegW = rw; MemW = mw; CntClr = clr;
    endtask

    task automatic step();
        logic p;
        logic [3:0] nf;
        p = ev(Cond, mf);
        nf = mf;
        if (FlagW[1] && mce) nf[3:2] = ALUFlags[3:2];
        if (FlagW[0] && mce) nf[1:0] = ALUFlags[1:0];
`ifdef COND_NV_TRAP_EN
        if (CntClr) mund = 0;
        else if (CondLatch && Cond == 4'hF) mund = 1;
`endif
        if (CntClr) mcnt = 0;
        else if (CondLatch && !p) mcnt = (mcnt + 1 > 15) ? 15 : mcnt + 1;
        if (CondLatch) mce = p;
        mf = nf;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        set(4'hE, 0, 0, 2'b11, 1, 1, 1, 1, 0);
        #12;
        check_all();
        @(negedge clk);
        reset = 0;
        set(4'hE, 0, 1, 0, 0, 0, 1, 0, 0); step();
        set(4'hE, 4'b0100, 0, 2'b11, 0, 0, 0, 0, 0); step();
        chk("flags_z", 16'(Flags), 16'h4);
        set(4'h1, 0, 1, 0, 1, 0, 0, 1, 0); step();
        chk("ne_squash", 16'(SquashCnt), 16'd1);
        set(4'hE, 0, 1, 0, 0, 0, 0, 0, 0); step();
        set(4'hE, 4'b1011, 0, 2'b10, 0, 0, 0, 0, 0); step();
        chk("nz_only", 16'(Flags), 16'h8);
        set(4'hE, 4'b1011, 0, 2'b01, 0, 0, 0, 0, 0); step();
        chk("cv_only", 16'(Flags), 16'hB);
        set(4'hE, 4'b1001, 0, 2'b11, 0, 0, 0, 0, 0); step();
        set(4'hC, 0, 1, 0, 0, 0, 1, 0, 0); step();
        chk("gt_pass", 16'(CondEx), 16'd1);
        set(4'hE, 4'b1101, 0, 2'b11, 0, 0, 0, 0, 0); step();
        set(4'hC, 0, 1, 0, 0, 0, 1, 0, 0); step();
        chk("gt_fail", 16'(CondEx), 16'd0);
        set(4'hE, 0, 1, 0, 0, 0, 0, 0, 0); step();
        set(4'hE, 4'b1001, 0, 2'b11, 0, 0, 0, 0, 0); step();
        set(4'hC, 4'b1101, 1, 2'b11, 0, 0, 0, 0, 0); step();
        chk("old_flags_decide", 16'(CondEx), 16'd1);
        chk("new_flags", 16'(Flags), 16'hD);
        for (int i = 0; i < 17; i++) begin
            set(4'h1, 0, 1, 0, 0, 0, 0, 0, 0); step();
        end
        chk("saturate", 16'(SquashCnt), 16'hF);
        set(4'h1, 0, 1, 0, 0, 0, 0, 0, 1); step();
        chk("clr_priority", 16'(SquashCnt), 16'h0);
        set(4'hE, 0, 1, 0, 0, 0, 0, 0, 0); step();
        set(4'hF, 0, 1, 0, 0, 0, 0, 0, 0); step();
        chk("nv_never", 16'(CondEx), 16'd0);
        chk("nv_count", 16'(SquashCnt), 16'd1);
        set(4'hE, 0, 1, 0, 0, 0, 0, 0, 0); step();
        set(4'hE, 0, 0, 0, 1, 0, 1, 1, 0);
        #3 reset = 1;
        #1;
        model_reset();
        check_all();
        chk("async_condex", 16'(CondEx), 16'd0);
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 400; i++) begin
            set(4'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 19) == 0);
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cond_sequencer.md
# cond_sequencer

Conditional-execution controller for the multicycle ARMv4 core. It holds the architectural NZCV flag register and evaluates each instruction's 4-bit condition field against it. It latches the pass/fail result for the rest of the instruction, and gates every architectural write (PC, register file, memory, flags) issued by the main control FSM. It sits between the control FSM/decoder and the datapath write enables. It also keeps a saturating count of squashed instructions for debug.

## Interface
Parameters:
- CNT_W, 16, width of the squashed-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- Cond  in  4  condition field of the current instruction (Instr[31:28]).
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the current operation.
- CondLatch  in  1  one-cycle strobe from the control FSM at end of decode; captures pass/fail.
- FlagW  in  2  FlagW[1] updates N,Z; FlagW[0] updates C,V.
- PCS  in  1  instruction writes PC (branch or Rd=15).
- NextPC  in  1  unconditional PC increment (fetch).
- RegW  in  1  register-file write request.
- MemW  in  1  memory write request.
- CntClr  in  1  synchronous clear of the squash counter and Undef.
- Flags  out  4  registered {N,Z,C,V}.
- CondEx  out  1  registered pass/fail of the current instruction.
- PCWrite  out  1  gated PC write enable.
- RegWrite  out  1  gated register write enable.
- MemWrite  out  1  gated memory write enable.
- SquashCnt  out  CNT_W  count of instructions that failed their condition.
- Undef  out  1  sticky NV-encoding indicator (see Configuration).

## Operation
- Condition evaluation is combinational on registered Flags; ge = (N == V).
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C.
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~(C&~Z); 1010 GE ge; 1011 LT ~ge.
  - 1100 GT ~Z&ge; 1101 LE ~(~Z&ge); 1110 AL 1.
  - 1111 evaluates to 0 (never); it is never X.
- On CondLatch: CondEx <= evaluated result; otherwise CondEx holds.
- Gating, combinational from registered CondEx:
  - PCWrite = (PCS & CondEx) | NextPC.
  - RegWrite = RegW & CondEx.
  - MemWrite = MemW & CondEx.
- Flag update per edge:
  - If FlagW[1] & CondEx: N,Z <= ALUFlags[3:2].
  - If FlagW[0] & CondEx: C,V <= ALUFlags[1:0].
  - The two halves are independent.
- Squash counter:
  - On CondLatch with a failing evaluation, SquashCnt increments.
  - It saturates at all-ones; it never wraps.
- CntClr clears SquashCnt (and Undef) and has priority over an increment in the same cycle.

## Timing
- Reset (asynchronous, immediate): Flags=0000, CondEx=0, SquashCnt=0, Undef=0. Consequently PCWrite=NextPC, RegWrite=0, MemWrite=0.
- Latency:
  - CondLatch at edge k → CondEx valid after edge k.
  - The gated enables reflect it in cycle k+1.
- CondLatch and a flag write in the same cycle: evaluation uses the pre-update Flags. New flags are visible from the next cycle.
- The flag write in that same cycle is gated by the old CondEx, i.e. the previous instruction's latched result. The control FSM never asserts FlagW during decode.
- NextPC is never gated. The fetch increment occurs even when CondEx=0.
- Reset asserted mid-instruction clears CondEx at once, and all gated writes except NextPC drop in the same cycle.

## Configuration
- Macro COND_NV_TRAP_EN.
- Defined:
  - CondLatch with Cond=1111 sets Undef to 1 (sticky until CntClr or reset).
  - CondEx <= 0, and the instruction counts as squashed.
- Not defined:
  - Undef is tied to 0.
  - 1111 behaves purely as "never" and still counts as squashed.

## Test plan
- Reset, then Cond=1110, CondLatch, RegW=1 → CondEx=1 and RegWrite=1 next cycle; Flags=0000; SquashCnt=0.
- Flags=0100 (Z=1), Cond=0001 (NE), CondLatch, MemW=1, PCS=1, NextPC=0 → CondEx=0, MemWrite=0, PCWrite=0, SquashCnt=1.
- CondEx=1, FlagW=10, ALUFlags=1011 → Flags becomes 1000 (only N,Z updated). Then FlagW=01 → Flags=1011.
- Flags=1001 (N=V), Cond=1100 (GT) → CondEx=1; Flags=1101 (Z=1) → CondEx=0. Also perform CondLatch concurrent with a flag change and confirm the old flags decide.
- CNT_W=4: 17 failing CondLatch strobes → SquashCnt=1111. Assert CntClr together with a failing CondLatch → SquashCnt=0.
- Cond=1111, CondLatch → CondEx=0, SquashCnt+1. Undef=1 with COND_NV_TRAP_EN, 0 without. Then async reset mid-cycle → all outputs at reset values immediately.
